// File: rtl/auto_load_seq_pkg.sv
// Shared definitions for the BPI flash auto-load sequencer: opcodes, FSM
// states and status-word bit positions.
package bpi_al_pkg;

  localparam logic [15:0] READ_ARRAY_CMD = 16'h00FF;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_CMD  = 2'b01;
  localparam logic [1:0] OP_READ = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_WCMD = 3'd2,
    ST_RD   = 3'd3,
    ST_WRD  = 3'd4,
    ST_NXT  = 3'd5,
    ST_DONE = 3'd6,
    ST_ABRT = 3'd7
  } al_state_e;

  localparam int STAT_COMPLETED = 0;
  localparam int STAT_ABORTED   = 1;
  localparam int STAT_TIMEOUT   = 2;
  localparam int STAT_CHKERR    = 3;

endpackage

// File: rtl/auto_load_seq_if.sv
// BPI engine bus as seen by the auto-load sequencer (master) and the
// BPI engine (slave).
interface auto_load_seq_if #(
  parameter int ADDR_W = 23,
  parameter int CNT_W  = 6
);

  logic              BUSY;
  logic              AL_DONE;
  logic [15:0]       RD_DATA;
  logic [ADDR_W-1:0] AL_ADDR;
  logic [15:0]       AL_CMD_DATA_OUT;
  logic [1:0]        AL_OP;
  logic              AL_EXECUTE;
  logic              AUTO_LOAD_ENA;
  logic              CLR_AL_DONE;
  logic [CNT_W-1:0]  AL_CNT;

  modport master (
    input  BUSY, AL_DONE, RD_DATA,
    output AL_ADDR, AL_CMD_DATA_OUT, AL_OP, AL_EXECUTE,
           AUTO_LOAD_ENA, CLR_AL_DONE, AL_CNT
  );

  modport slave (
    output BUSY, AL_DONE, RD_DATA,
    input  AL_ADDR, AL_CMD_DATA_OUT, AL_OP, AL_EXECUTE,
           AUTO_LOAD_ENA, CLR_AL_DONE, AL_CNT
  );

endinterface

// File: rtl/auto_load_seq_fsm.sv
// Sequencer control: state register, per-operation timeout and retry
// counters, and the execute/clear strobes towards the BPI engine.
module auto_load_seq_fsm
  import bpi_al_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1023,
  parameter int MAX_RETRY   = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      start_i,
  input  logic      abort_i,
  input  logic      busy_i,
  input  logic      done_i,
  input  logic      last_word_i,
  output al_state_e state_o,
  output logic      execute_o,
  output logic      ena_o,
  output logic [1:0] op_o,
  output logic      clr_o,
  output logic      start_acc_o,
  output logic      rd_acc_o,
  output logic      cnt_inc_o,
  output logic      tmo_o
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);

  al_state_e        state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [RTY_W-1:0] rty_q, rty_d;
  logic             clr_q, clr_d;
  logic             tmo_hit;

  assign state_o = state_q;
  assign clr_o   = clr_q;
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
      rty_q   <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      rty_q   <= rty_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    rty_d       = rty_q;
    clr_d       = 1'b0;
    execute_o   = 1'b0;
    ena_o       = 1'b0;
    op_o        = OP_NONE;
    start_acc_o = 1'b0;
    rd_acc_o    = 1'b0;
    cnt_inc_o   = 1'b0;
    tmo_o       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          start_acc_o = 1'b1;
          rty_d       = '0;
          state_d     = ST_CMD;
        end
      end

      // Execute is gated by BUSY combinationally so it can never overlap it.
      ST_CMD, ST_RD: begin
        ena_o = 1'b1;
        op_o  = (state_q == ST_CMD) ? OP_CMD : OP_READ;
        if (abort_i) begin
          state_d = ST_ABRT;
        end else if (!busy_i) begin
          execute_o = 1'b1;
          tmo_d     = '0;
          state_d   = (state_q == ST_CMD) ? ST_WCMD : ST_WRD;
        end
      end

      // Abort wins over a coincident done: no clear, no capture.
      ST_WCMD, ST_WRD: begin
        ena_o = 1'b1;
        op_o  = (state_q == ST_WCMD) ? OP_CMD : OP_READ;
        if (abort_i) begin
          state_d = ST_ABRT;
        end else if (done_i) begin
          clr_d    = 1'b1;
          rty_d    = '0;
          rd_acc_o = (state_q == ST_WRD);
          state_d  = (state_q == ST_WCMD) ? ST_RD : ST_NXT;
        end else if (tmo_hit) begin
          tmo_o = 1'b1;
          rty_d = rty_q + 1'b1;
          if (rty_q >= RTY_W'(MAX_RETRY)) begin
            state_d = ST_ABRT;
          end else begin
            state_d = (state_q == ST_WCMD) ? ST_CMD : ST_RD;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_NXT: begin
        ena_o = 1'b1;
        if (abort_i) begin
          state_d = ST_ABRT;
        end else if (last_word_i) begin
          state_d = ST_DONE;
        end else begin
          cnt_inc_o = 1'b1;
          state_d   = ST_RD;
        end
      end

      ST_DONE: begin
        state_d = abort_i ? ST_ABRT : ST_IDLE;
      end

      ST_ABRT: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/auto_load_seq.sv
// Flash auto-load sequencer: reads a parameter block over the BPI engine,
// streams it into constant storage and verifies a trailing checksum word.
module auto_load_seq
  import bpi_al_pkg::*;
#(
  parameter int                ADDR_W      = 23,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 23'h7FC000,
  parameter int                N_WORDS     = 34,
  parameter int                CNT_W       = 6,
  parameter int                TIMEOUT_CYC = 1023,
  parameter int                MAX_RETRY   = 2,
  parameter int                CHK_ENA     = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             AL_START,
  input  logic             AL_ABORT,
  auto_load_seq_if.master  bpi,
  output logic             AL_WE,
  output logic [CNT_W-1:0] AL_WADDR,
  output logic [15:0]      AL_WDATA,
  output logic [3:0]       AL_STATUS
);

  if (N_WORDS < 2 || N_WORDS > (1 << CNT_W)) begin : g_bad_nwords
    $error("auto_load_seq: N_WORDS must lie in 2..2**CNT_W");
  end
  if (BASE_ADDR[CNT_W-1:0] != '0) begin : g_bad_base
    $error("auto_load_seq: BASE_ADDR must be aligned to 2**CNT_W");
  end

  al_state_e        state;
  logic             start_acc, rd_acc, cnt_inc, tmo_evt, last_word;

  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      sum_q;
  logic             we_q;
  logic [CNT_W-1:0] waddr_q;
  logic [15:0]      wdata_q;
  logic [3:0]       status_q;

  assign last_word           = (cnt_q == CNT_W'(N_WORDS - 1));
  assign bpi.AL_ADDR         = {BASE_ADDR[ADDR_W-1:CNT_W], cnt_q};
  assign bpi.AL_CMD_DATA_OUT = READ_ARRAY_CMD;
  assign bpi.AL_CNT          = cnt_q;
  assign AL_WE               = we_q;
  assign AL_WADDR            = waddr_q;
  assign AL_WDATA            = wdata_q;
  assign AL_STATUS           = status_q;

  auto_load_seq_fsm #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .MAX_RETRY   (MAX_RETRY)
  ) u_fsm (
    .clk         (CLK),
    .rst_n       (RST_N),
    .start_i     (AL_START),
    .abort_i     (AL_ABORT),
    .busy_i      (bpi.BUSY),
    .done_i      (bpi.AL_DONE),
    .last_word_i (last_word),
    .state_o     (state),
    .execute_o   (bpi.AL_EXECUTE),
    .ena_o       (bpi.AUTO_LOAD_ENA),
    .op_o        (bpi.AL_OP),
    .clr_o       (bpi.CLR_AL_DONE),
    .start_acc_o (start_acc),
    .rd_acc_o    (rd_acc),
    .cnt_inc_o   (cnt_inc),
    .tmo_o       (tmo_evt)
  );

  // The checksum word joins the sum but is not written to storage when checked.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q    <= '0;
      sum_q    <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      status_q <= '0;
    end else begin
      we_q <= rd_acc && !((CHK_ENA != 0) && last_word);
      if (start_acc) begin
        cnt_q    <= '0;
        sum_q    <= '0;
        status_q <= '0;
      end
      if (cnt_inc) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (rd_acc) begin
        waddr_q <= cnt_q;
        wdata_q <= bpi.RD_DATA;
        sum_q   <= sum_q + bpi.RD_DATA;
      end
      if (tmo_evt) begin
        status_q[STAT_TIMEOUT] <= 1'b1;
      end
      if (state == ST_DONE) begin
        status_q[STAT_COMPLETED] <= 1'b1;
        if ((CHK_ENA != 0) && (sum_q != 16'h0000)) begin
          status_q[STAT_CHKERR] <= 1'b1;
        end
      end
      if (state == ST_ABRT) begin
        status_q[STAT_ABORTED] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_auto_load_seq.sv
// Randomised scoreboard bench for auto_load_seq with a behavioural BPI
// engine model and a word-level reference model of the expected load.
module tb_auto_load_seq;
  import bpi_al_pkg::*;

  localparam int                ADDR_W    = 23;
  localparam int                CNT_W     = 6;
  localparam int                N         = 34;
  localparam int                TMO       = 15;
  localparam int                MAX_RETRY = 2;
  localparam logic [ADDR_W-1:0] BASE      = 23'h7FC000;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             AL_START = 1'b0;
  logic             AL_ABORT;
  logic             AL_WE;
  logic [CNT_W-1:0] AL_WADDR;
  logic [15:0]      AL_WDATA;
  logic [3:0]       AL_STATUS;

  auto_load_seq_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bpi ();

  auto_load_seq #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .N_WORDS(N), .CNT_W(CNT_W),
    .TIMEOUT_CYC(TMO), .MAX_RETRY(MAX_RETRY), .CHK_ENA(1)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .AL_START(AL_START), .AL_ABORT(AL_ABORT),
    .bpi(bpi), .AL_WE(AL_WE), .AL_WADDR(AL_WADDR), .AL_WDATA(AL_WDATA),
    .AL_STATUS(AL_STATUS)
  );

  always #5 CLK = ~CLK;

  // Scenario knobs and flash contents
  logic [15:0] mem  [N];
  int          drop [N];
  int          seen [N];
  int          abort_word = -1;
  int          pre_busy   = 0;
  logic        eng_flush  = 1'b0;

  // BPI engine model
  logic        pend_q = 1'b0, pend_rd = 1'b0, done_q = 1'b0, abt_q = 1'b0;
  logic [15:0] data_q = '0;
  int          lat_q = 0, pend_idx = 0, pre_q = 0;
  int          eng_idx;
  logic        eng_rd;

  assign eng_idx     = int'(bpi.AL_ADDR[CNT_W-1:0]);
  assign eng_rd      = (bpi.AL_OP == OP_READ);
  assign bpi.BUSY    = pend_q || (pre_q > 0);
  assign bpi.AL_DONE = done_q;
  assign bpi.RD_DATA = data_q;
  assign AL_ABORT    = abt_q;

  always @(posedge CLK) begin
    abt_q <= 1'b0;
    if (eng_flush) begin
      pend_q <= 1'b0;
      done_q <= 1'b0;
      pre_q  <= pre_busy;
      for (int i = 0; i < N; i++) seen[i] <= 0;
    end else begin
      if (bpi.CLR_AL_DONE) begin
        done_q <= 1'b0;
        pre_q  <= pre_busy;
      end else if (pre_q > 0) begin
        pre_q <= pre_q - 1;
      end
      if (bpi.AL_EXECUTE) begin
        if (eng_rd && seen[eng_idx] < drop[eng_idx]) begin
          seen[eng_idx] <= seen[eng_idx] + 1;
        end else begin
          pend_q   <= 1'b1;
          lat_q    <= int'($urandom_range(1, 4));
          pend_idx <= eng_idx;
          pend_rd  <= eng_rd;
        end
      end else if (pend_q) begin
        if (lat_q <= 1) begin
          pend_q <= 1'b0;
          done_q <= 1'b1;
          data_q <= pend_rd ? mem[pend_idx] : 16'hDEAD;
          if (pend_rd && pend_idx == abort_word) abt_q <= 1'b1;
        end else begin
          lat_q <= lat_q - 1;
        end
      end
    end
  end

  // Scoreboard
  typedef struct packed { logic [1:0] op; logic [ADDR_W-1:0] addr; } op_t;
  typedef struct packed { logic [CNT_W-1:0] a; logic [15:0] d; } wr_t;
  op_t exp_ops[$];
  wr_t exp_wr[$];
  int  clr_seen = 0;
  int  n_tests  = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_step();
    op_t eo;
    wr_t ew;
    if (!RST_N) begin
      if (AL_WE || bpi.AL_EXECUTE || bpi.CLR_AL_DONE)
        check("strobe_in_reset", {29'd0, AL_WE, bpi.AL_EXECUTE, bpi.CLR_AL_DONE}, 32'd0);
      return;
    end
    if (bpi.AL_EXECUTE) begin
      check("exec_while_busy", {31'd0, bpi.BUSY}, 32'd0);
      if (exp_ops.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_exec: op %0d addr %0h, none expected", bpi.AL_OP, bpi.AL_ADDR);
      end else begin
        eo = exp_ops.pop_front();
        check("exec_op", {30'd0, bpi.AL_OP}, {30'd0, eo.op});
        check("exec_addr", {9'd0, bpi.AL_ADDR}, {9'd0, eo.addr});
      end
    end
    if (AL_WE) begin
      check("we_with_clr", {31'd0, bpi.CLR_AL_DONE}, 32'd1);
      if (exp_wr.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_we: waddr %0d wdata %0h, none expected", AL_WADDR, AL_WDATA);
      end else begin
        ew = exp_wr.pop_front();
        check("we_addr", {26'd0, AL_WADDR}, {26'd0, ew.a});
        check("we_data", {16'd0, AL_WDATA}, {16'd0, ew.d});
      end
    end
    if (bpi.CLR_AL_DONE) clr_seen++;
  endtask

  always @(negedge CLK) mon_step();

  // Reference model: what a load of mem[] must produce, word by word
  task automatic build_expect(output logic [3:0] st, output int nclr);
    int sum;
    bit aborted;
    sum = 0; aborted = 0; st = 4'b0000; nclr = 1;
    exp_ops.push_back(op_t'{op: OP_CMD, addr: BASE});
    for (int i = 0; i < N && !aborted; i++) begin
      int tries;
      tries = (drop[i] > MAX_RETRY) ? MAX_RETRY + 1 : drop[i] + 1;
      for (int k = 0; k < tries; k++)
        exp_ops.push_back(op_t'{op: OP_READ, addr: ADDR_W'(BASE + i)});
      if (drop[i] > 0) st[2] = 1'b1;
      if (drop[i] > MAX_RETRY || i == abort_word) begin
        aborted = 1;
      end else begin
        sum += int'(mem[i]);
        nclr++;
        if (i != N - 1) exp_wr.push_back(wr_t'{a: CNT_W'(i), d: mem[i]});
      end
    end
    if (aborted) st[1] = 1'b1;
    else begin
      st[0] = 1'b1;
      if ((sum % 65536) != 0) st[3] = 1'b1;
    end
  endtask

  task automatic fill_mem(input bit rnd);
    int sum;
    sum = 0;
    for (int i = 0; i < N - 1; i++) begin
      mem[i] = rnd ? 16'($urandom) : 16'(i + 1);
      sum += int'(mem[i]);
    end
    mem[N-1] = 16'(-sum);
    for (int i = 0; i < N; i++) drop[i] = 0;
    abort_word = -1;
  endtask

  task automatic start_load(output logic [3:0] exp_st, output int exp_clr);
    exp_ops.delete();
    exp_wr.delete();
    eng_flush = 1'b1;
    @(negedge CLK);
    eng_flush = 1'b0;
    clr_seen = 0;
    build_expect(exp_st, exp_clr);
    AL_START = 1'b1;
    @(negedge CLK);
    AL_START = 1'b0;
  endtask

  task automatic run_load(input string name, input int budget, input int extra_start);
    logic [3:0] exp_st;
    int exp_clr;
    int cyc;
    start_load(exp_st, exp_clr);
    cyc = 0;
    while (!(AL_STATUS[0] || AL_STATUS[1]) && cyc < budget) begin
      @(negedge CLK);
      cyc++;
      AL_START = (cyc == extra_start);
    end
    AL_START = 1'b0;
    if (!(AL_STATUS[0] || AL_STATUS[1])) begin
      n_tests++; n_fail++;
      $display("FAIL %s_finish: status %b after %0d cycles, expected completion", name, AL_STATUS, budget);
    end
    @(negedge CLK);
    check({name, "_status"}, {28'd0, AL_STATUS}, {28'd0, exp_st});
    check({name, "_ena"}, {31'd0, bpi.AUTO_LOAD_ENA}, 32'd0);
    check({name, "_ops_left"}, exp_ops.size(), 32'd0);
    check({name, "_wr_left"}, exp_wr.size(), 32'd0);
    check({name, "_clr_count"}, clr_seen, exp_clr);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_we"}, {31'd0, AL_WE}, 32'd0);
    check({name, "_exec"}, {31'd0, bpi.AL_EXECUTE}, 32'd0);
    check({name, "_ena"}, {31'd0, bpi.AUTO_LOAD_ENA}, 32'd0);
    check({name, "_clr"}, {31'd0, bpi.CLR_AL_DONE}, 32'd0);
    check({name, "_op"}, {30'd0, bpi.AL_OP}, 32'd0);
    check({name, "_cnt"}, {26'd0, bpi.AL_CNT}, 32'd0);
    check({name, "_addr"}, {9'd0, bpi.AL_ADDR}, 32'h007FC000);
    check({name, "_cmd"}, {16'd0, bpi.AL_CMD_DATA_OUT}, 32'h000000FF);
    check({name, "_status"}, {28'd0, AL_STATUS}, 32'd0);
    check({name, "_waddr"}, {26'd0, AL_WADDR}, 32'd0);
    check({name, "_wdata"}, {16'd0, AL_WDATA}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] st;
    int nclr;
    int cyc;
    fill_mem(0);
    #1;
    check_reset_outputs("por");
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // Nominal load with an ignored START mid-load
    fill_mem(0);
    run_load("nominal", 1500, 40);

    // Checksum word off by one
    fill_mem(0);
    mem[N-1] = mem[N-1] + 16'd1;
    run_load("chk_err", 1500, -1);

    // Read 5 never completes: three executes, then abort
    fill_mem(1);
    drop[5] = 3;
    run_load("timeout", 1500, -1);

    // One dropped completion on word 10
    fill_mem(1);
    drop[10] = 1;
    run_load("retry", 1500, -1);

    // Abort coincident with the completion of word 7
    fill_mem(1);
    abort_word = 7;
    run_load("abort", 1500, -1);

    // Scattered drops up to the retry limit; the retry count must clear between words
    fill_mem(1);
    for (int i = 0; i < N; i++)
      drop[i] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, MAX_RETRY)) : 0;
    run_load("rand_retry", 3000, -1);

    // Slow engine, reset mid-load, then a full load
    fill_mem(1);
    pre_busy = 20;
    start_load(st, nclr);
    cyc = 0;
    while (exp_wr.size() > N - 1 - 5 && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
    end
    if (exp_wr.size() > N - 1 - 5) begin
      n_tests++; n_fail++;
      $display("FAIL midload_progress: %0d writes pending after %0d cycles, expected <= %0d",
               exp_wr.size(), cyc, N - 1 - 5);
    end
    #2;
    RST_N = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_ops.delete();
    exp_wr.delete();
    eng_flush = 1'b1;
    repeat (3) @(negedge CLK);
    eng_flush = 1'b0;
    RST_N = 1'b1;
    @(negedge CLK);
    run_load("after_reset", 4000, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/auto_load_seq.md
Name: auto_load_seq

Overview:
- Parametrised auto-load sequencer for the BPI flash interface.
- After power-up or on request, it issues a Read-Array command, then reads N_WORDS consecutive 16-bit constants from a flash parameter block.
- Each word is streamed into a constant-storage write port.
- The last word is verified as a checksum. Per-operation timeout and retry are provided, plus a sticky status word for the slow-control readback.

Parameters:
- ADDR_W, 23, flash word-address width.
- BASE_ADDR, 23'h7FC000, first word address; must be aligned to 2**CNT_W.
- N_WORDS, 34, words read, including the trailing checksum word; range 2..2**CNT_W.
- CNT_W, 6, word-counter width.
- TIMEOUT_CYC, 1023, CLK cycles allowed from EXECUTE to AL_DONE.
- MAX_RETRY, 2, re-issues of one operation before abort.
- CHK_ENA, 1, 1 = trailing-word checksum checked; 0 = no check, all words stored.

Ports:
- CLK, in, 1: system clock.
- RST_N, in, 1: reset; asynchronous, active-low.
- AL_START, in, 1: one-cycle start request.
- AL_ABORT, in, 1: synchronous abort request.
- BUSY, in, 1: BPI engine busy.
- AL_DONE, in, 1: BPI operation complete; level, held until cleared.
- RD_DATA, in, 16: flash read data, valid while AL_DONE=1.
- AL_ADDR, out, ADDR_W: BASE_ADDR[ADDR_W-1:CNT_W] concatenated with AL_CNT.
- AL_CMD_DATA_OUT, out, 16: constant 16'h00FF (Read-Array).
- AL_OP, out, 2: 2'b01 = command write, 2'b10 = read.
- AL_EXECUTE, out, 1: one-cycle operation strobe.
- AUTO_LOAD_ENA, out, 1: sequencer owns the BPI bus.
- CLR_AL_DONE, out, 1: one-cycle clear of the engine's AL_DONE.
- AL_CNT, out, CNT_W: current word index.
- AL_WE, out, 1: constant-storage write strobe.
- AL_WADDR, out, CNT_W: storage address.
- AL_WDATA, out, 16: storage data.
- AL_STATUS, out, 4: bit 0 completed, bit 1 aborted, bit 2 timeout seen, bit 3 checksum error.

Behaviour:
- Reset (RST_N=0, immediate): FSM goes to IDLE. All outputs 0 except AL_CMD_DATA_OUT and AL_ADDR (AL_ADDR = BASE_ADDR with AL_CNT=0). Retry, timeout and sum registers clear. Reset asserted mid-load abandons the load; no further AL_WE is issued.
- States:
  - IDLE: on AL_START, clear AL_STATUS, AL_CNT and sum; go to CMD.
  - CMD: AL_OP=01, AUTO_LOAD_ENA=1. Wait until BUSY=0, then pulse AL_EXECUTE and go to WCMD.
  - WCMD: on AL_DONE, pulse CLR_AL_DONE and go to RD.
  - RD: AL_OP=10. When BUSY=0, pulse AL_EXECUTE and go to WRD.
  - WRD: on AL_DONE, capture RD_DATA, add it to the 16-bit modulo sum, pulse CLR_AL_DONE.
    - Pulse AL_WE with AL_WADDR=AL_CNT and AL_WDATA=RD_DATA. Suppress this write for the checksum word when CHK_ENA=1.
    - Go to NXT.
  - NXT: if AL_CNT==N_WORDS-1, go to DONE. Otherwise increment AL_CNT and go to RD.
  - DONE: set STATUS[0]. If CHK_ENA=1 and sum≠0, also set STATUS[3]. Drop AUTO_LOAD_ENA and go to IDLE.
  - ABRT: set STATUS[1], drop AUTO_LOAD_ENA, go to IDLE.
- Handshake:
  - AL_EXECUTE is never asserted while BUSY=1.
  - AL_EXECUTE and CLR_AL_DONE are exactly one cycle each.
  - Latency from AL_DONE to CLR_AL_DONE and AL_WE is 1 cycle (registered; both occur on the same cycle).
- Timeout:
  - The counter starts on AL_EXECUTE and runs in WCMD/WRD.
  - Reaching TIMEOUT_CYC sets STATUS[2] and increments the retry count.
  - If retry ≤ MAX_RETRY, return to CMD or RD with the same AL_CNT; otherwise go to ABRT.
  - The retry count clears on each successful operation.
- AL_ABORT in any non-IDLE state goes to ABRT next cycle. AL_ABORT has priority over a simultaneous AL_DONE: no write, no CLR.
- AL_START while not IDLE is ignored.
- STATUS bits are sticky until the next accepted AL_START or reset.
- The AL_CNT wrap is unreachable by the parameter constraint. An elaboration-time check rejects N_WORDS > 2**CNT_W or N_WORDS < 2.

Decomposition:
- Shared package bpi_al_pkg:
  - Constant READ_ARRAY_CMD = 16'h00FF.
  - OP_CMD = 2'b01 and OP_READ = 2'b10.
  - FSM state enum.
  - STATUS bit indices.
- One sub-module: auto_load_seq_fsm, containing state, timeout/retry counters and strobes.
- The parent holds address formation, data/sum registers and AL_STATUS.

Test Plan:
- Nominal load (N_WORDS=34, BPI model data = index+1, last word = negated sum), START pulse:
  - Response: one CMD op, then 34 reads.
  - Addresses 0x7FC000..0x7FC021.
  - 33 AL_WE writes.
  - Final AL_STATUS=4'b0001.
- Corrupted checksum (word 33 off by 1) -> AL_STATUS=4'b1001; the 33 writes still occur.
- Engine never returns AL_DONE on read 5 (TIMEOUT_CYC=15, MAX_RETRY=2):
  - Response: 3 EXECUTEs at AL_ADDR=0x7FC005.
  - Final AL_STATUS=4'b0110; AUTO_LOAD_ENA=0.
- Single dropped AL_DONE on word 10 -> exactly one retry; load completes with AL_STATUS=4'b0101.
- AL_ABORT on the same cycle as AL_DONE of word 7 -> no AL_WE for word 7, no CLR_AL_DONE; AL_STATUS=4'b0010.
- BUSY held high for 20 cycles before each op; RST_N low mid-load:
  - No EXECUTE is issued while BUSY=1.
  - Reset clears all outputs immediately.
  - A new START then performs a full load.
